// File: rtl/td4_pkg.sv
// Shared TD4 program-loader definitions: FSM states and program byte field layout.
package td4_pkg;

  localparam int PC_W    = 4;
  localparam int FIELD_W = 4;
  localparam int OPC_LSB = 0;
  localparam int IMM_LSB = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

endpackage

// File: rtl/td4_prog_mem.sv
// DEPTH x 8 program store: one synchronous write port, zero-latency asynchronous read port.
// Synchronous active-low reset clears every word; no flow control of its own.
module td4_prog_mem #(
  parameter int DEPTH = 16,
  parameter int PC_W  = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            we,
  input  logic [PC_W-1:0] waddr,
  input  logic [7:0]      wdata,
  input  logic [PC_W-1:0] raddr,
  output logic [7:0]      rdata
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= 8'h00;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/td4_prog_loader.sv
// Loads a DEPTH-byte TD4 program from a valid/ready host stream, then releases the CPU.
// Fetch is combinational (zero latency); wr_ready follows load_en while loading, 0 otherwise.
module td4_prog_loader #(
  parameter int DEPTH = 16,
  parameter int PC_W  = td4_pkg::PC_W
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_en,
  input  logic            wr_valid,
  input  logic [7:0]      wr_data,
  output logic            wr_ready,
  input  logic [PC_W-1:0] pc,
  output logic [3:0]      opcode,
  output logic [3:0]      immediate,
  output logic            cpu_run,
  output logic            load_done,
  output logic [7:0]      checksum
);

  import td4_pkg::*;

  state_t          state;
  state_t          state_nxt;
  logic [PC_W-1:0] addr;
  logic [PC_W-1:0] addr_nxt;
  logic [7:0]      csum_nxt;
  logic            done_nxt;
  logic            xfer;
  logic [7:0]      rdata;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      addr      <= '0;
      checksum  <= 8'h00;
      load_done <= 1'b0;
    end else begin
      state     <= state_nxt;
      addr      <= addr_nxt;
      checksum  <= csum_nxt;
      load_done <= done_nxt;
    end
  end

  // Every way into LOAD restarts the address and checksum, so a reload never mixes programs.
  always_comb begin
    state_nxt = state;
    addr_nxt  = addr;
    csum_nxt  = checksum;
    done_nxt  = 1'b0;
    wr_ready  = 1'b0;
    xfer      = 1'b0;
    case (state)
      IDLE: begin
        if (load_en) begin
          state_nxt = LOAD;
          addr_nxt  = '0;
          csum_nxt  = 8'h00;
        end
      end
      LOAD: begin
        wr_ready = load_en;
        if (!load_en) begin
          state_nxt = IDLE;
        end else if (wr_valid) begin
          xfer     = 1'b1;
          addr_nxt = addr + PC_W'(1);
          csum_nxt = checksum + wr_data;
          if (addr == PC_W'(DEPTH - 1)) begin
            state_nxt = RUN;
            done_nxt  = 1'b1;
          end
        end
      end
      RUN: begin
        if (load_en) begin
          state_nxt = LOAD;
          addr_nxt  = '0;
          csum_nxt  = 8'h00;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  td4_prog_mem #(
    .DEPTH (DEPTH),
    .PC_W  (PC_W)
  ) u_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (xfer),
    .waddr (addr),
    .wdata (wr_data),
    .raddr (pc),
    .rdata (rdata)
  );

  assign cpu_run   = (state == RUN);
  assign opcode    = cpu_run ? rdata[OPC_LSB +: FIELD_W] : 4'h0;
  assign immediate = cpu_run ? rdata[IMM_LSB +: FIELD_W] : 4'h0;

endmodule

// File: tb/tb_td4_prog_loader.sv
// Directed bench for td4_prog_loader: fetch-vector table plus load/abort/reload/reset sequences.
module tb_td4_prog_loader;

  logic       clk;
  logic       rst_n;
  logic       load_en;
  logic       wr_valid;
  logic [7:0] wr_data;
  logic       wr_ready;
  logic [3:0] pc;
  logic [3:0] opcode;
  logic [3:0] immediate;
  logic       cpu_run;
  logic       load_done;
  logic [7:0] checksum;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [3:0] pc;
    logic [7:0] dat;
    logic [3:0] opc;
    logic [3:0] imm;
  } vec_t;

  vec_t vt [16];

  td4_prog_loader #(.DEPTH(16), .PC_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_en   (load_en),
    .wr_valid  (wr_valid),
    .wr_data   (wr_data),
    .wr_ready  (wr_ready),
    .pc        (pc),
    .opcode    (opcode),
    .immediate (immediate),
    .cpu_run   (cpu_run),
    .load_done (load_done),
    .checksum  (checksum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full 16-byte load from IDLE or RUN; bytes are base+i when incr, else base.
  task automatic do_load(input logic [7:0] base, input bit incr, input logic [7:0] exp_csum);
    logic [7:0] b;
    load_en  = 1'b1;
    wr_valid = 1'b1;
    wr_data  = 8'hEE;
    #1;
    check("ready_outside_load", {31'd0, wr_ready}, 32'd0);
    tick();
    check("entry_cpu_run", {31'd0, cpu_run}, 32'd0);
    check("entry_checksum", {24'd0, checksum}, 32'd0);
    for (int i = 0; i < 16; i++) begin
      b        = incr ? base + 8'(i) : base;
      wr_valid = 1'b1;
      wr_data  = b;
      #1;
      check("load_ready", {31'd0, wr_ready}, 32'd1);
      check("load_done_early", {31'd0, load_done}, 32'd0);
      tick();
    end
    load_en  = 1'b0;
    wr_valid = 1'b0;
    check("load_done_pulse", {31'd0, load_done}, 32'd1);
    check("run_after_load", {31'd0, cpu_run}, 32'd1);
    check("load_checksum", {24'd0, checksum}, {24'd0, exp_csum});
    tick();
    check("load_done_one_cycle", {31'd0, load_done}, 32'd0);
    check("run_holds", {31'd0, cpu_run}, 32'd1);
    check("checksum_holds_run", {24'd0, checksum}, {24'd0, exp_csum});
  endtask

  task automatic sweep_const(input string name, input logic [3:0] opc, input logic [3:0] imm);
    for (int i = 0; i < 16; i++) begin
      pc = 4'(i);
      #1;
      check({name, "_opc"}, {28'd0, opcode}, {28'd0, opc});
      check({name, "_imm"}, {28'd0, immediate}, {28'd0, imm});
    end
  endtask

  initial begin
    int n;
    int cyc;

    vt[0]  = '{4'd0,  8'h3C, 4'hC, 4'h3};
    vt[1]  = '{4'd1,  8'hA5, 4'h5, 4'hA};
    vt[2]  = '{4'd2,  8'h07, 4'h7, 4'h0};
    vt[3]  = '{4'd3,  8'hF1, 4'h1, 4'hF};
    vt[4]  = '{4'd4,  8'h5E, 4'hE, 4'h5};
    vt[5]  = '{4'd5,  8'h80, 4'h0, 4'h8};
    vt[6]  = '{4'd6,  8'h2B, 4'hB, 4'h2};
    vt[7]  = '{4'd7,  8'h69, 4'h9, 4'h6};
    vt[8]  = '{4'd8,  8'hD4, 4'h4, 4'hD};
    vt[9]  = '{4'd9,  8'h1F, 4'hF, 4'h1};
    vt[10] = '{4'd10, 8'hC2, 4'h2, 4'hC};
    vt[11] = '{4'd11, 8'h48, 4'h8, 4'h4};
    vt[12] = '{4'd12, 8'h9D, 4'hD, 4'h9};
    vt[13] = '{4'd13, 8'hE6, 4'h6, 4'hE};
    vt[14] = '{4'd14, 8'h73, 4'h3, 4'h7};
    vt[15] = '{4'd15, 8'hBA, 4'hA, 4'hB};

    rst_n    = 1'b0;
    load_en  = 1'b0;
    wr_valid = 1'b0;
    wr_data  = 8'h00;
    pc       = 4'd0;
    tick();
    tick();
    check("rst_cpu_run", {31'd0, cpu_run}, 32'd0);
    check("rst_wr_ready", {31'd0, wr_ready}, 32'd0);
    check("rst_load_done", {31'd0, load_done}, 32'd0);
    check("rst_opcode", {28'd0, opcode}, 32'd0);
    check("rst_immediate", {28'd0, immediate}, 32'd0);
    check("rst_checksum", {24'd0, checksum}, 32'd0);
    rst_n = 1'b1;
    tick();
    check("idle_cpu_run", {31'd0, cpu_run}, 32'd0);

    // Full load of 0x00..0x0F, then zero-latency fetch sweep.
    do_load(8'h00, 1'b1, 8'h78);
    for (int i = 0; i < 16; i++) begin
      pc = 4'(i);
      #1;
      check("sweep_opc", {28'd0, opcode}, i);
      check("sweep_imm", {28'd0, immediate}, 32'd0);
    end

    // Backpressured load of the vector table from RUN.
    load_en  = 1'b1;
    wr_valid = 1'b0;
    tick();
    n   = 0;
    cyc = 0;
    while (n < 16 && cyc < 400) begin
      wr_valid = ($urandom_range(0, 1) == 1);
      wr_data  = vt[n].dat;
      #1;
      check("bp_ready", {31'd0, wr_ready}, 32'd1);
      @(posedge clk);
      if (wr_valid) n++;
      cyc++;
      #1;
      if (n == 16) begin
        load_en  = 1'b0;
        wr_valid = 1'b0;
        check("bp_done", {31'd0, load_done}, 32'd1);
        check("bp_run", {31'd0, cpu_run}, 32'd1);
      end else begin
        check("bp_done_early", {31'd0, load_done}, 32'd0);
      end
    end
    if (n != 16) begin
      load_en  = 1'b0;
      wr_valid = 1'b0;
      check("bp_timeout_transfers", n, 32'd16);
    end
    check("bp_checksum", {24'd0, checksum}, 32'hF8);
    for (int i = 15; i >= 0; i--) begin
      pc = vt[i].pc;
      #1;
      check("vt_opc", {28'd0, opcode}, {28'd0, vt[i].opc});
      check("vt_imm", {28'd0, immediate}, {28'd0, vt[i].imm});
    end
    tick();
    check("bp_done_one_cycle", {31'd0, load_done}, 32'd0);

    // Abort after 5 bytes.
    pc      = 4'd0;
    load_en = 1'b1;
    tick();
    check("abort_entry_run", {31'd0, cpu_run}, 32'd0);
    check("abort_entry_csum", {24'd0, checksum}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      wr_valid = 1'b1;
      wr_data  = 8'hA1 + 8'(i);
      tick();
    end
    load_en = 1'b0;
    wr_data = 8'hA6;
    #1;
    check("abort_ready", {31'd0, wr_ready}, 32'd0);
    tick();
    check("abort_cpu_run", {31'd0, cpu_run}, 32'd0);
    check("abort_opcode", {28'd0, opcode}, 32'd0);
    check("abort_immediate", {28'd0, immediate}, 32'd0);
    check("abort_load_done", {31'd0, load_done}, 32'd0);
    check("abort_checksum", {24'd0, checksum}, 32'h2F);
    tick();
    check("idle_ignores_valid", {24'd0, checksum}, 32'h2F);
    check("idle_stays", {31'd0, cpu_run}, 32'd0);

    // Later full load overwrites from address 0.
    do_load(8'hFF, 1'b0, 8'hF0);
    sweep_const("ff", 4'hF, 4'hF);

    // Reload from RUN.
    load_en = 1'b1;
    #1;
    check("reload_run_same_cycle", {31'd0, cpu_run}, 32'd1);
    do_load(8'h11, 1'b0, 8'h10);
    pc = 4'd7;
    #1;
    check("reload_mem7_opc", {28'd0, opcode}, 32'h1);
    check("reload_mem7_imm", {28'd0, immediate}, 32'h1);
    sweep_const("r11", 4'h1, 4'h1);

    // Reset after 8 bytes of a load.
    load_en = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      wr_valid = 1'b1;
      wr_data  = 8'h55;
      tick();
    end
    rst_n = 1'b0;
    tick();
    check("mrst_cpu_run", {31'd0, cpu_run}, 32'd0);
    check("mrst_wr_ready", {31'd0, wr_ready}, 32'd0);
    check("mrst_load_done", {31'd0, load_done}, 32'd0);
    check("mrst_opcode", {28'd0, opcode}, 32'd0);
    check("mrst_immediate", {28'd0, immediate}, 32'd0);
    check("mrst_checksum", {24'd0, checksum}, 32'd0);
    rst_n    = 1'b1;
    load_en  = 1'b0;
    wr_valid = 1'b0;
    tick();
    check("mrst_idle", {31'd0, cpu_run}, 32'd0);
    do_load(8'h00, 1'b0, 8'h00);
    sweep_const("zero", 4'h0, 4'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
